// File: rtl/map_pkg.sv
// Shared constants for the map renderer: cell codes, fixed colours and the
// code-to-colour palette used by the output stage.
package map_pkg;

  localparam int CODE_W = 4;

  localparam logic [3:0] CELL_FREE     = 4'd0;
  localparam logic [3:0] CELL_WALL     = 4'd1;
  localparam logic [3:0] CELL_BLACK    = 4'd2;
  localparam logic [3:0] CELL_DEBRIS_L = 4'd3;
  localparam logic [3:0] CELL_DEBRIS_M = 4'd4;
  localparam logic [3:0] CELL_DEBRIS_H = 4'd5;

  localparam logic [11:0] COLOUR_BLANK   = 12'h000;
  localparam logic [11:0] COLOUR_BORDER  = 12'h00F;
  localparam logic [11:0] COLOUR_GRID    = 12'h888;
  localparam logic [11:0] COLOUR_ROBOT   = 12'h0F0;
  localparam logic [11:0] COLOUR_INVALID = 12'hF0F;

  // Codes above the debris range are shown in a loud marker colour so map
  // corruption is obvious on screen.
  function automatic logic [11:0] palette(input logic [3:0] code);
    logic [11:0] colour;
    case (code)
      CELL_FREE:     colour = 12'hCCC;
      CELL_WALL:     colour = 12'h444;
      CELL_BLACK:    colour = 12'h000;
      CELL_DEBRIS_L: colour = 12'hFC0;
      CELL_DEBRIS_M: colour = 12'hF80;
      CELL_DEBRIS_H: colour = 12'hF00;
      default:       colour = COLOUR_INVALID;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with undelayed sync, data-enable and
// frame-start strobes; enable=0 parks the scan at the origin.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  parameter int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  parameter int HW       = $clog2(H_TOTAL),
  parameter int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          line_end,
  output logic          frame_end,
  output logic          hsync_pre,
  output logic          vsync_pre,
  output logic          de_pre,
  output logic          frame_start_pre
);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  assign line_end  = (h == H_LAST);
  assign frame_end = line_end && (v == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (!enable) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign hsync_pre       = !((h >= HS_FIRST) && (h <= HS_LAST));
  assign vsync_pre       = !((v >= VS_FIRST) && (v <= VS_LAST));
  assign de_pre          = (h < H_ACT) && (v < V_ACT);
  assign frame_start_pre = (h == '0) && (v == '0);

endmodule

// File: rtl/map_renderer.sv
// Raster renderer for the robot map: walks the cell grid incrementally,
// fetches cell codes from a 1-cycle RAM and produces a 2-stage RGB pipeline.
module map_renderer #(
  parameter int ROWS         = 11,
  parameter int COLS         = 20,
  parameter int CELL_W       = 32,
  parameter int CELL_H       = 32,
  parameter int CODE_W       = map_pkg::CODE_W,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 16,
  parameter int AW           = $clog2(ROWS * COLS),
  parameter int RW           = $clog2(ROWS),
  parameter int CW           = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [AW-1:0]     map_addr,
  input  logic [CODE_W-1:0] map_data,
  input  logic [RW-1:0]     robot_row,
  input  logic [CW-1:0]     robot_col,
  input  logic              robot_valid,
  input  logic              removing,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [11:0]       rgb,
  output logic              frame_start
);
  import map_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PXW     = $clog2(CELL_W);
  localparam int PYW     = $clog2(CELL_H);
  // Cell counters keep running through blanking, so size them for the
  // whole raster rather than just the grid.
  localparam int CCW     = $clog2(H_TOTAL / CELL_W + 2);
  localparam int CRW     = $clog2(V_TOTAL / CELL_H + 2);
  localparam int FCW     = $clog2(BLINK_FRAMES + 1);

  localparam logic [HW-1:0]  GRID_W     = HW'(COLS * CELL_W);
  localparam logic [VW-1:0]  GRID_H     = VW'(ROWS * CELL_H);
  localparam logic [AW-1:0]  COLS_A     = AW'(COLS);
  localparam logic [FCW-1:0] BLINK_LAST = FCW'(BLINK_FRAMES - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          line_end, frame_end;
  logic          hsync_pre, vsync_pre, de_pre, frame_start_pre;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW),       .VW   (VW)
  ) u_timing (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .h               (h),
    .v               (v),
    .line_end        (line_end),
    .frame_end       (frame_end),
    .hsync_pre       (hsync_pre),
    .vsync_pre       (vsync_pre),
    .de_pre          (de_pre),
    .frame_start_pre (frame_start_pre)
  );

  logic [PXW-1:0] px;
  logic [PYW-1:0] py;
  logic [CCW-1:0] cell_col;
  logic [CRW-1:0] cell_row;

  // Cell position tracks h/v in lock-step; power-of-two cell sizes let the
  // sub-counters wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px       <= '0;
      py       <= '0;
      cell_col <= '0;
      cell_row <= '0;
    end else if (!enable) begin
      px       <= '0;
      py       <= '0;
      cell_col <= '0;
      cell_row <= '0;
    end else if (line_end) begin
      px       <= '0;
      cell_col <= '0;
      if (frame_end) begin
        py       <= '0;
        cell_row <= '0;
      end else begin
        py <= py + 1'b1;
        if (py == '1) cell_row <= cell_row + 1'b1;
      end
    end else begin
      px <= px + 1'b1;
      if (px == '1) cell_col <= cell_col + 1'b1;
    end
  end

  logic          in_grid;
  logic          grid_line;
  logic [AW-1:0] addr_now;
  logic [AW-1:0] addr_hold;

  assign in_grid   = (h < GRID_W) && (v < GRID_H);
  assign grid_line = (px == '0) || (py == '0);
  assign addr_now  = AW'(cell_row) * COLS_A + AW'(cell_col);
  assign map_addr  = in_grid ? addr_now : addr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       addr_hold <= '0;
    else if (!enable) addr_hold <= '0;
    else              addr_hold <= map_addr;
  end

  logic          robot_valid_s, removing_s;
  logic [RW-1:0] robot_row_s;
  logic [CW-1:0] robot_col_s;
  logic [FCW-1:0] frame_cnt;
  logic          blink;

  // Robot inputs are latched once at the raster origin so a move never
  // tears the overlay within a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      robot_valid_s <= 1'b0;
      removing_s    <= 1'b0;
      robot_row_s   <= '0;
      robot_col_s   <= '0;
    end else if (enable && frame_start_pre) begin
      robot_valid_s <= robot_valid;
      removing_s    <= removing;
      robot_row_s   <= robot_row;
      robot_col_s   <= robot_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (!enable) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic robot_hit, show_robot;

  assign robot_hit  = robot_valid_s && in_grid &&
                      (cell_row == CRW'(robot_row_s)) &&
                      (cell_col == CCW'(robot_col_s));
  assign show_robot = robot_hit && !(removing_s && blink);

  logic de_1, hs_1, vs_1, fs_1, grid_1, line_1, robot_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_1 <= 1'b0; hs_1 <= 1'b1; vs_1 <= 1'b1; fs_1 <= 1'b0;
      grid_1 <= 1'b0; line_1 <= 1'b0; robot_1 <= 1'b0;
    end else if (!enable) begin
      de_1 <= 1'b0; hs_1 <= 1'b1; vs_1 <= 1'b1; fs_1 <= 1'b0;
      grid_1 <= 1'b0; line_1 <= 1'b0; robot_1 <= 1'b0;
    end else begin
      de_1    <= de_pre;
      hs_1    <= hsync_pre;
      vs_1    <= vsync_pre;
      fs_1    <= frame_start_pre;
      grid_1  <= in_grid;
      line_1  <= grid_line;
      robot_1 <= show_robot;
    end
  end

  logic [31:0] code_ext;
  logic [11:0] code_colour;
  logic [11:0] colour;

  assign code_ext    = 32'(map_data);
  assign code_colour = (code_ext > 32'd15) ? COLOUR_INVALID : palette(code_ext[3:0]);

  // map_data arrives during stage 1, alongside the flags captured with it.
  always_comb begin
    colour = COLOUR_BLANK;
    if (!de_1)        colour = COLOUR_BLANK;
    else if (!grid_1) colour = COLOUR_BORDER;
    else if (line_1)  colour = COLOUR_GRID;
    else if (robot_1) colour = COLOUR_ROBOT;
    else              colour = code_colour;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1; vsync <= 1'b1; de <= 1'b0; frame_start <= 1'b0; rgb <= COLOUR_BLANK;
    end else if (!enable) begin
      hsync <= 1'b1; vsync <= 1'b1; de <= 1'b0; frame_start <= 1'b0; rgb <= COLOUR_BLANK;
    end else begin
      hsync       <= hs_1;
      vsync       <= vs_1;
      de          <= de_1;
      frame_start <= fs_1;
      rgb         <= colour;
    end
  end

endmodule
